uart_tx_dev: RTL and testbench

- Memory-mapped UART transmitter peripheral that sits on one Bridge device slot, alongside the TC timers.
- Acts as a bus responder: the CPU writes bytes through the Bridge, and the block serialises them on txd in 8N1 format from a small FIFO.
- Raises IRQ into DevInt when its FIFO drains, so software can refill it under interrupt.

---
 rtl/uart_tx_dev_pkg.sv | 26 ++
 rtl/uart_tx_dev_if.sv | 10 +
 rtl/uart_tx_fifo.sv | 53 +++++
 rtl/uart_tx_dev.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_dev.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the UART transmitter peripheral: register map,
// control/status bit positions and FSM state encoding.
package uart_tx_dev_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_DIV    = 2'd1;
   localparam logic [1:0] REG_DATA   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int CTRL_TX_EN  = 0;
   localparam int CTRL_IRQ_EN = 1;

   localparam int STAT_EMPTY     = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_BUSY      = 2;
   localparam int STAT_OVF       = 3;
   localparam int STAT_COUNT_LSB = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/uart_tx_dev_if.sv
// Bridge device-slot bus: word address, write strobe, write and read data.
interface uart_tx_dev_if;
   logic [31:2] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;

   modport master (output Addr, output WE, output Din, input Dout);
   modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with combinational head output; DEPTH is a power of two.
module uart_tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_pop  = pop & ~empty;
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: register file, FIFO, baud timer, shifter, IRQ.
//   state    | meaning
//   ST_IDLE  | line idle high, waiting for TX_EN and a queued byte
//   ST_START | start bit (low) for div_q+1 clocks
//   ST_DATA  | eight data bits, LSB first, div_q+1 clocks each
//   ST_STOP  | stop bit (high); may pop the next byte straight into ST_START
module uart_tx_dev
   import uart_tx_dev_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd433
) (
   input  logic             clk,
   input  logic             reset,
   uart_tx_dev_if.slave     bus,
   output logic             IRQ,
   output logic             txd
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_e     state_q, state_d;
   logic [1:0]    ctrl_q;
   logic [15:0]   div_reg_q;
   logic          ovf_q;
   logic [15:0]   div_q;
   logic [15:0]   baud_cnt_q;
   logic [2:0]    bit_idx_q;
   logic [7:0]    shift_q;
   logic          txd_q, txd_d;
   logic          irq_q, irq_d;

   logic          tx_en, irq_en, baud_tc;
   logic          wr_ctrl, wr_div, wr_data, wr_status;
   logic          fifo_pop, fifo_empty, fifo_full;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic [31:0]   status;
   logic          unused_bus_bits;

   assign tx_en     = ctrl_q[CTRL_TX_EN];
   assign irq_en    = ctrl_q[CTRL_IRQ_EN];
   assign baud_tc   = (baud_cnt_q == 16'd0);
   assign wr_ctrl   = bus.WE & (bus.Addr[3:2] == REG_CTRL);
   assign wr_div    = bus.WE & (bus.Addr[3:2] == REG_DIV);
   assign wr_data   = bus.WE & (bus.Addr[3:2] == REG_DATA);
   assign wr_status = bus.WE & (bus.Addr[3:2] == REG_STATUS);
   assign unused_bus_bits = ^{bus.Addr[31:4], bus.Din[31:16]};

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_data),
      .pop   (fifo_pop),
      .din   (bus.Din[7:0]),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q    <= 2'b00;
         div_reg_q <= DIV_RESET;
         ovf_q     <= 1'b0;
      end else begin
         if (wr_ctrl) ctrl_q    <= bus.Din[1:0];
         if (wr_div)  div_reg_q <= bus.Din[15:0];
         if (wr_status)
            ovf_q <= 1'b0;
         else if (wr_data && fifo_full && !fifo_pop)
            ovf_q <= 1'b1;
      end
   end

   always_comb begin
      status                           = '0;
      status[STAT_EMPTY]               = fifo_empty;
      status[STAT_FULL]                = fifo_full;
      status[STAT_BUSY]                = (state_q != ST_IDLE);
      status[STAT_OVF]                 = ovf_q;
      status[STAT_COUNT_LSB +: 4]      = 4'(fifo_count);
      case (bus.Addr[3:2])
         REG_CTRL:   bus.Dout = {30'd0, ctrl_q};
         REG_DIV:    bus.Dout = {16'd0, div_reg_q};
         REG_STATUS: bus.Dout = status;
         default:    bus.Dout = 32'd0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      fifo_pop = 1'b0;
      case (state_q)
         ST_IDLE:
            if (tx_en && !fifo_empty) begin
               fifo_pop = 1'b1;
               state_d  = ST_START;
            end
         ST_START:
            if (baud_tc) state_d = ST_DATA;
         ST_DATA:
            if (baud_tc && bit_idx_q == 3'd7) state_d = ST_STOP;
         ST_STOP:
            if (baud_tc) begin
               if (tx_en && !fifo_empty) begin
                  fifo_pop = 1'b1;
                  state_d  = ST_START;
               end else begin
                  state_d  = ST_IDLE;
               end
            end
         default: state_d = ST_IDLE;
      endcase

      // txd is registered from the next state so the line and the FSM move together
      case (state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = (state_q == ST_DATA && baud_tc) ? shift_q[1] : shift_q[0];
         default:  txd_d = 1'b1;
      endcase

      irq_d = irq_en & fifo_empty & (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         txd_q   <= 1'b1;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         txd_q   <= txd_d;
         irq_q   <= irq_d;
      end
   end

   // baud timer counts down from div_q; terminal count ends the current bit
   always_ff @(posedge clk) begin
      if (reset) begin
         baud_cnt_q <= 16'd0;
         div_q      <= 16'd0;
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'd0;
      end else if (fifo_pop) begin
         shift_q    <= fifo_dout;
         div_q      <= div_reg_q;
         baud_cnt_q <= div_reg_q;
         bit_idx_q  <= 3'd0;
      end else if (state_q != ST_IDLE) begin
         if (baud_tc) begin
            baud_cnt_q <= div_q;
            if (state_q == ST_DATA) begin
               shift_q   <= shift_q >> 1;
               bit_idx_q <= bit_idx_q + 3'd1;
            end
         end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
         end
      end
   end

   assign txd = txd_q;
   assign IRQ = irq_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev: register-access vector table plus frame-level sequences.
module tb_uart_tx_dev;
   import uart_tx_dev_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic IRQ;
   logic txd;

   uart_tx_dev_if bus();

   uart_tx_dev #(.FIFO_DEPTH(4), .DIV_RESET(16'd433)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .IRQ   (IRQ),
      .txd   (txd)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          wr;
      logic [1:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus.Addr = {28'd0, a};
      bus.Din  = d;
      bus.WE   = 1'b1;
      step();
      bus.WE   = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bus.Addr = {28'd0, a};
      #1;
      d = bus.Dout;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      bus.WE   = 1'b0;
      bus.Addr = '0;
      bus.Din  = '0;
      repeat (2) step();
      reset    = 1'b0;
   endtask

   // first sample lands on the cycle after the edge that popped the byte
   task automatic check_frame(input logic [7:0] b, input int div, input bit chk_busy,
                              input bit chk_irq, input string tag);
      logic [31:0] st;
      int          slot;
      logic        exp;
      for (int k = 0; k < 10 * (div + 1); k++) begin
         step();
         slot = k / (div + 1);
         if (slot == 0)      exp = 1'b0;
         else if (slot == 9) exp = 1'b1;
         else                exp = b[slot-1];
         chk($sformatf("%s txd k=%0d", tag, k), {31'd0, txd}, {31'd0, exp});
         if (chk_irq) chk($sformatf("%s irq k=%0d", tag, k), {31'd0, IRQ}, 32'd0);
         if (chk_busy) begin
            bus_read(REG_STATUS, st);
            chk($sformatf("%s busy k=%0d", tag, k), {31'd0, st[STAT_BUSY]}, 32'd1);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int          lows;

      vecs[0]  = '{1'b0, REG_CTRL,   32'h0,        32'h0};
      vecs[1]  = '{1'b0, REG_DIV,    32'h0,        32'd433};
      vecs[2]  = '{1'b0, REG_DATA,   32'h0,        32'h0};
      vecs[3]  = '{1'b0, REG_STATUS, 32'h0,        32'h001};
      vecs[4]  = '{1'b1, REG_DIV,    32'hABCD1234, 32'h0};
      vecs[5]  = '{1'b0, REG_DIV,    32'h0,        32'h1234};
      vecs[6]  = '{1'b1, REG_CTRL,   32'hFFFFFFFE, 32'h0};
      vecs[7]  = '{1'b0, REG_CTRL,   32'h0,        32'h2};
      vecs[8]  = '{1'b1, REG_CTRL,   32'h0,        32'h0};
      vecs[9]  = '{1'b0, REG_CTRL,   32'h0,        32'h0};
      vecs[10] = '{1'b1, REG_DATA,   32'h5A,       32'h0};
      vecs[11] = '{1'b0, REG_STATUS, 32'h0,        32'h100};
      vecs[12] = '{1'b1, REG_DATA,   32'h5B,       32'h0};
      vecs[13] = '{1'b1, REG_DATA,   32'h5C,       32'h0};
      vecs[14] = '{1'b1, REG_DATA,   32'h5D,       32'h0};
      vecs[15] = '{1'b0, REG_STATUS, 32'h0,        32'h402};
      vecs[16] = '{1'b1, REG_DATA,   32'h5E,       32'h0};
      vecs[17] = '{1'b0, REG_STATUS, 32'h0,        32'h40A};
      vecs[18] = '{1'b1, REG_STATUS, 32'h0,        32'h0};
      vecs[19] = '{1'b0, REG_STATUS, 32'h0,        32'h402};

      // reset state and register-access table
      do_reset();
      chk("reset txd", {31'd0, txd}, 32'd1);
      chk("reset irq", {31'd0, IRQ}, 32'd0);
      for (int i = 0; i < 20; i++) begin
         if (vecs[i].wr) begin
            bus_write(vecs[i].a, vecs[i].d);
         end else begin
            bus_read(vecs[i].a, rd);
            chk($sformatf("vec%0d read a=%0d", i, vecs[i].a), rd, vecs[i].exp);
         end
      end

      // single 0xA5 frame at DIV=3, BUSY held throughout
      do_reset();
      bus_write(REG_DIV, 32'd3);
      bus_write(REG_CTRL, 32'h1);
      bus_write(REG_DATA, 32'hA5);
      chk("a5 txd idle before pop", {31'd0, txd}, 32'd1);
      check_frame(8'hA5, 3, 1'b1, 1'b0, "a5");
      step();
      bus_read(REG_STATUS, rd);
      chk("a5 txd after frame", {31'd0, txd}, 32'd1);
      chk("a5 status after frame", rd, 32'h001);

      // overflow, then back-to-back frames at DIV=0
      do_reset();
      bus_write(REG_DIV, 32'd0);
      for (int i = 0; i < 5; i++) bus_write(REG_DATA, 32'h11 + i);
      bus_read(REG_STATUS, rd);
      chk("ovf status full", rd, 32'h40A);
      bus_write(REG_CTRL, 32'h1);
      for (int i = 0; i < 4; i++)
         check_frame(8'h11 + 8'(i), 0, 1'b1, 1'b0, $sformatf("b2b%0d", i));
      step();
      bus_read(REG_STATUS, rd);
      chk("b2b txd idle", {31'd0, txd}, 32'd1);
      chk("b2b status drained", rd, 32'h009);
      bus_write(REG_STATUS, 32'h0);
      bus_read(REG_STATUS, rd);
      chk("ovf cleared", rd, 32'h001);

      // interrupt behaviour
      do_reset();
      bus_write(REG_DIV, 32'd1);
      bus_write(REG_CTRL, 32'h3);
      chk("irq low same cycle as enable", {31'd0, IRQ}, 32'd0);
      step();
      chk("irq high idle empty", {31'd0, IRQ}, 32'd1);
      bus_write(REG_DATA, 32'h96);
      chk("irq still high after push edge", {31'd0, IRQ}, 32'd1);
      check_frame(8'h96, 1, 1'b0, 1'b1, "irqf");
      step();
      chk("irq rises after stop", {31'd0, IRQ}, 32'd1);
      bus_write(REG_CTRL, 32'h1);
      chk("irq high on irq_en clear edge", {31'd0, IRQ}, 32'd1);
      step();
      chk("irq low after irq_en clear", {31'd0, IRQ}, 32'd0);

      // DIV change mid-frame applies only from the next pop
      do_reset();
      bus_write(REG_DIV, 32'd2);
      bus_write(REG_CTRL, 32'h1);
      bus_write(REG_DATA, 32'h0F);
      fork
         check_frame(8'h0F, 2, 1'b0, 1'b0, "div2");
         begin
            repeat (12) step();
            bus_write(REG_DIV, 32'd7);
            repeat (2) step();
            bus_write(REG_DATA, 32'hF0);
         end
      join
      check_frame(8'hF0, 7, 1'b0, 1'b0, "div7");
      step();
      chk("div7 txd idle", {31'd0, txd}, 32'd1);

      // reset mid-frame flushes the queue
      do_reset();
      bus_write(REG_DIV, 32'd1);
      bus_write(REG_DATA, 32'h81);
      bus_write(REG_DATA, 32'h42);
      bus_write(REG_DATA, 32'h24);
      bus_write(REG_CTRL, 32'h1);
      repeat (9) step();
      bus_read(REG_STATUS, rd);
      chk("rst 4th data bit", {31'd0, txd}, 32'd0);
      chk("rst status before", rd, 32'h204);
      reset = 1'b1;
      step();
      bus_read(REG_STATUS, rd);
      chk("rst txd high", {31'd0, txd}, 32'd1);
      chk("rst fifo empty", rd, 32'h001);
      reset = 1'b0;
      bus_write(REG_CTRL, 32'h1);
      lows = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (txd == 1'b0) lows++;
      end
      chk("rst no further frames", lows, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
